// File: rtl/priority_enc_4_2.sv
// Combinational 4-to-2 priority encoder: highest set line wins, err flags multi-hot input.
// Everything is forced to zero when en is low.
module priority_enc_4_2 (
    input  logic       en,
    input  logic [3:0] d,
    output logic [1:0] y_c,
    output logic       v_c,
    output logic       err_c
);

    always_comb begin
        y_c   = 2'd0;
        v_c   = 1'b0;
        err_c = 1'b0;
        if (en) begin
            v_c = |d;
            if (d[3])      y_c = 2'd3;
            else if (d[2]) y_c = 2'd2;
            else if (d[1]) y_c = 2'd1;
            else           y_c = 2'd0;
            // Clearing the lowest set bit leaves a residue only when two or more bits are set.
            err_c = (d & (d - 4'd1)) != 4'd0;
        end
    end

endmodule

// File: rtl/encoder_4_2_pipe.sv
// Valid/ready wrapped 4-to-2 priority encoder with a 2-entry result FIFO
// and a saturating count of accepted multi-hot words.
module encoder_4_2_pipe #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       d,
    input  logic             en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       y,
    output logic             v,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] y;
        logic       v;
        logic       err;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    entry_t           enc_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             accept_c;
    logic             pop_c;

    priority_enc_4_2 u_enc (
        .en    (en),
        .d     (d),
        .y_c   (enc_c.y),
        .v_c   (enc_c.v),
        .err_c (enc_c.err)
    );

    assign accept_c = in_valid && in_ready_q;
    assign pop_c    = out_valid_q && out_ready;

    // Next-state: head register doubles as the output register and is zero when empty.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;

        if (accept_c && enc_c.err && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    state_d = ST_ONE;
                    head_d  = enc_c;
                end
            end
            ST_ONE: begin
                if (accept_c && pop_c) begin
                    head_d = enc_c;
                end else if (accept_c) begin
                    state_d = ST_FULL;
                    tail_d  = enc_c;
                end else if (pop_c) begin
                    state_d = ST_EMPTY;
                    head_d  = '0;
                end
            end
            ST_FULL: begin
                if (pop_c) begin
                    state_d = ST_ONE;
                    head_d  = tail_q;
                    tail_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                head_d  = '0;
                tail_d  = '0;
            end
        endcase

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = head_q.y;
    assign v         = head_q.v;
    assign err       = head_q.err;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_encoder_4_2_pipe.sv
// Self-checking bench for encoder_4_2_pipe: queue-based reference model checked every
// negedge, plus directed literal checks; a CNT_W=2 copy shares the stimulus.
module tb_encoder_4_2_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] d;
    logic       en;
    logic       out_ready;

    logic       in_ready, out_valid, v, err;
    logic [1:0] y;
    logic [7:0] err_cnt;

    logic       s_in_ready, s_out_valid, s_v, s_err;
    logic [1:0] s_y;
    logic [1:0] s_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] y;
        logic       v;
        logic       err;
    } res_t;

    res_t        q[$];
    int unsigned m_cnt;
    int unsigned m_cnt_s;
    res_t        mon_e;
    res_t        exp_h;
    logic        mon_acc, mon_pop;

    always #5 clk = ~clk;

    encoder_4_2_pipe #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .en(en), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .v(v), .err(err), .err_cnt(err_cnt)
    );

    encoder_4_2_pipe #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .d(d), .en(en), .out_valid(s_out_valid), .out_ready(out_ready),
        .y(s_y), .v(s_v), .err(s_err), .err_cnt(s_err_cnt)
    );

    // Reference encoding from the rules: highest set index, any-set, count of set bits > 1.
    function automatic res_t model_enc(input logic e, input logic [3:0] dd);
        res_t r;
        int   n;
        r.y = 2'd0; r.v = 1'b0; r.err = 1'b0;
        n = 0;
        if (e) begin
            for (int i = 0; i < 4; i++) begin
                if (dd[i]) begin
                    r.y = 2'(i);
                    n++;
                end
            end
            r.v   = (n > 0);
            r.err = (n > 1);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: check DUT against the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_cnt   = 0;
            m_cnt_s = 0;
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_yve", 32'({y, v, err}), 32'd0);
            chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        end else begin
            if (q.size() > 0) exp_h = q[0];
            else begin exp_h.y = 2'd0; exp_h.v = 1'b0; exp_h.err = 1'b0; end
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("y", 32'(y), 32'(exp_h.y));
            chk("v", 32'(v), 32'(exp_h.v));
            chk("err", 32'(err), 32'(exp_h.err));
            chk("err_cnt", 32'(err_cnt), m_cnt);
            chk("s_err_cnt", 32'(s_err_cnt), m_cnt_s);
            chk("s_out", 32'({s_in_ready, s_out_valid, s_y, s_v, s_err}),
                32'({in_ready, out_valid, y, v, err}));
            mon_acc = in_valid && (q.size() < 2);
            mon_pop = (q.size() > 0) && out_ready;
            if (mon_pop) void'(q.pop_front());
            if (mon_acc) begin
                mon_e = model_enc(en, d);
                q.push_back(mon_e);
                if (mon_e.err) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt_s < 3) m_cnt_s++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Present a word and hold it until it is taken; bounded wait.
    task automatic push_wait(input logic e, input logic [3:0] dd);
        logic taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        en       = e;
        d        = dd;
        for (int k = 0; k < 20 && !taken; k++) begin
            taken = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!taken) chk("push_timeout", 32'd0, 32'd1);
    endtask

    res_t pin;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        en        = 1'b0;
        d         = 4'd0;
        out_ready = 1'b1;

        pin = model_enc(1'b1, 4'b0100);
        chk("pin_0100", 32'({pin.y, pin.v, pin.err}), 32'b1010);
        pin = model_enc(1'b0, 4'b1111);
        chk("pin_en0", 32'({pin.y, pin.v, pin.err}), 32'b0000);
        pin = model_enc(1'b1, 4'b1010);
        chk("pin_1010", 32'({pin.y, pin.v, pin.err}), 32'b1111);
        pin = model_enc(1'b1, 4'b0000);
        chk("pin_0000", 32'({pin.y, pin.v, pin.err}), 32'b0000);

        // Full {en,d} sweep, one word at a time.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            logic [4:0] iv;
            iv = 5'(i);
            push_wait(iv[4], iv[3:0]);
            chk("sweep_latency", 32'(out_valid), 32'd1);
            if (iv == 5'b10100) chk("sweep_0100", 32'({y, v, err}), 32'b1010);
            if (iv == 5'b01111) chk("sweep_en0", 32'({y, v, err}), 32'b0000);
            step();
        end

        // Two multi-hot words back to back.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; en = 1'b1; d = 4'b1010;
        step();
        chk("mh1", 32'({y, err}), 32'b111);
        d = 4'b0011;
        step();
        chk("mh2", 32'({y, err}), 32'b011);
        in_valid = 1'b0;
        step();
        chk("mh_cnt", 32'(err_cnt), 32'd2);

        // Backpressure: three words with consumer stalled.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; en = 1'b1; d = 4'b0001;
        step();
        d = 4'b0010;
        step();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        d = 4'b0100;
        step();
        chk("bp_held", 32'({in_ready, out_valid, y}), 32'b0100);
        out_ready = 1'b1;
        step();
        chk("bp_pop1", 32'({in_ready, y}), 32'b101);
        step();
        chk("bp_acc3", 32'({out_valid, y}), 32'b110);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Streaming in ONE: accept and pop every cycle.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; en = 1'b1; d = 4'b1000;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 4'($urandom_range(15));
            step();
            chk("stream_one", 32'({out_valid, in_ready}), 32'b11);
        end
        in_valid = 1'b0;
        step();

        // Saturation of the narrow counter.
        do_reset();
        out_ready = 1'b1;
        push_wait(1'b1, 4'b1100);
        push_wait(1'b1, 4'b0110);
        push_wait(1'b1, 4'b1111);
        push_wait(1'b1, 4'b0101);
        push_wait(1'b1, 4'b1001);
        step();
        chk("sat_small", 32'(s_err_cnt), 32'd3);
        chk("sat_wide", 32'(err_cnt), 32'd5);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            en        = ($urandom_range(7) != 0);
            d         = 4'($urandom_range(15));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        in_valid = 1'b1; en = 1'b1; d = 4'b1110;
        step();
        step();
        in_valid = 1'b0;
        chk("ar_full", 32'({in_ready, out_valid, y, v, err}), 32'b011111);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_outs", 32'({out_valid, y, v, err}), 32'd0);
        chk("ar_cnt", 32'(err_cnt), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ar_after", 32'(out_valid), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
